// File: rtl/dig_scan_ctrl.sv
// Bus-programmable 8-digit seven-segment scan controller with double-buffered display word.
// Optional macro DIG_DP_EN enables user-controlled decimal points from ctrl[15:8].
module dig_scan_ctrl #(
  parameter int unsigned REFRESH_END   = 1999,
  parameter int unsigned REFRESH_WIDTH = 20,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter logic [31:0] DATA_ADDR     = 32'hFFFF_F000,
  parameter logic [31:0] CTRL_ADDR     = 32'hFFFF_F004
) (
  input  logic        clk_from_bg,
  input  logic        rst_from_bg,
  input  logic [31:0] addr_from_bg,
  input  logic        we_from_bg,
  input  logic [31:0] wdata_from_bg,
  output logic [7:0]  dig_en_2_soc,
  output logic [7:0]  dig_DN_2_soc,
  output logic        frame_start_2_soc
);

  typedef enum logic [1:0] {OFF, GAP, SHOW} state_t;

  state_t                   state, state_nxt;
  logic [REFRESH_WIDTH-1:0] slot_cnt, slot_nxt;
  logic [2:0]               idx, idx_nxt;
  logic                     latch;
  logic [31:0]              shadow_data, frame_data, frame_data_nxt;
  logic [16:0]              shadow_ctrl, shadow_ctrl_nxt, frame_ctrl, frame_ctrl_nxt;
  logic [7:0]               dig_en_nxt, dig_dn_nxt, mask_nxt;
  logic [3:0]               nib;
  logic                     dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  // Control register write; without decimal-point support the dp byte is never stored.
  always_comb begin
    shadow_ctrl_nxt = shadow_ctrl;
    if (we_from_bg && (addr_from_bg == CTRL_ADDR)) begin
`ifdef DIG_DP_EN
      shadow_ctrl_nxt = wdata_from_bg[16:0];
`else
      shadow_ctrl_nxt = {wdata_from_bg[16], 8'h00, wdata_from_bg[7:0]};
`endif
    end
  end

`ifndef DIG_DP_EN
  logic unused_dp_bits;
  assign unused_dp_bits = ^wdata_from_bg[15:8];
`endif

  // Next-state, frame latch and next-cycle outputs; outputs are registered from next-state values.
  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot_cnt;
    idx_nxt        = idx;
    latch          = 1'b0;
    dig_en_nxt     = 8'hFF;
    dig_dn_nxt     = 8'hFF;
    case (state)
      OFF: begin
        state_nxt = GAP;
        slot_nxt  = '0;
        idx_nxt   = 3'd0;
        latch     = 1'b1;
      end
      GAP: begin
        slot_nxt = slot_cnt + REFRESH_WIDTH'(1);
        if (slot_cnt == REFRESH_WIDTH'(GAP_CYCLES - 1)) state_nxt = SHOW;
      end
      SHOW: begin
        if (slot_cnt == REFRESH_WIDTH'(REFRESH_END)) begin
          slot_nxt  = '0;
          idx_nxt   = idx + 3'd1;
          state_nxt = GAP;
          latch     = (idx == 3'd7);
        end else begin
          slot_nxt = slot_cnt + REFRESH_WIDTH'(1);
        end
      end
      default: state_nxt = OFF;
    endcase

    frame_data_nxt = latch ? shadow_data : frame_data;
    frame_ctrl_nxt = {shadow_ctrl[16], latch ? shadow_ctrl[15:0] : frame_ctrl[15:0]};
    mask_nxt       = frame_ctrl_nxt[7:0];
    nib            = 4'(frame_data_nxt >> {idx_nxt, 2'b00});
`ifdef DIG_DP_EN
    dp             = frame_ctrl_nxt[8 + 32'(idx_nxt)];
`else
    dp             = 1'b0;
`endif
    if (state_nxt == SHOW) begin
      dig_dn_nxt = {~dp, ~seg_decode(nib)};
      if (mask_nxt[idx_nxt] && !frame_ctrl_nxt[16]) dig_en_nxt = ~(8'h01 << idx_nxt);
    end
  end

  always_ff @(posedge clk_from_bg or posedge rst_from_bg) begin
    if (rst_from_bg) begin
      state             <= OFF;
      slot_cnt          <= '0;
      idx               <= 3'd0;
      shadow_data       <= '0;
      shadow_ctrl       <= '0;
      frame_data        <= '0;
      frame_ctrl        <= '0;
      dig_en_2_soc      <= 8'hFF;
      dig_DN_2_soc      <= 8'hFF;
      frame_start_2_soc <= 1'b0;
    end else begin
      state             <= state_nxt;
      slot_cnt          <= slot_nxt;
      idx               <= idx_nxt;
      shadow_ctrl       <= shadow_ctrl_nxt;
      frame_data        <= frame_data_nxt;
      frame_ctrl        <= frame_ctrl_nxt;
      dig_en_2_soc      <= dig_en_nxt;
      dig_DN_2_soc      <= dig_dn_nxt;
      frame_start_2_soc <= latch;
      if (we_from_bg && (addr_from_bg == DATA_ADDR)) shadow_data <= wdata_from_bg;
    end
  end

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Randomized scoreboard bench for dig_scan_ctrl: a frame-time model predicts every output cycle.
module tb_dig_scan_ctrl;
  localparam int unsigned RE    = 9;
  localparam int unsigned GAPC  = 2;
  localparam int unsigned SLOT  = RE + 1;
  localparam int unsigned FRAME = 8 * SLOT;
  localparam logic [31:0] DADDR = 32'hFFFF_F000;
  localparam logic [31:0] CADDR = 32'hFFFF_F004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  dig_en, dig_dn;
  logic        fs;

  dig_scan_ctrl #(
    .REFRESH_END(RE), .REFRESH_WIDTH(4), .GAP_CYCLES(GAPC),
    .DATA_ADDR(DADDR), .CTRL_ADDR(CADDR)
  ) dut (
    .clk_from_bg(clk), .rst_from_bg(rst), .addr_from_bg(addr),
    .we_from_bg(we), .wdata_from_bg(wdata),
    .dig_en_2_soc(dig_en), .dig_DN_2_soc(dig_dn), .frame_start_2_soc(fs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] dn;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Model state: position inside the 80-cycle frame plus the register images.
  bit          started = 1'b0;
  int          t = 0;
  logic [31:0] m_sd = '0, m_fd = '0;
  logic [16:0] m_sc = '0;
  logic [15:0] m_fc = '0;
  logic        m_blank = 1'b0;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[n];
  endfunction

  // Reference model: one prediction per rising edge, for the cycle that edge starts.
  initial begin
    logic [31:0] old_sd;
    logic [16:0] old_sc;
    exp_t        e;
    int          slot, pos;
    logic        dp;
    forever begin
      @(posedge clk);
      if (rst) begin
        started = 1'b0; t = 0;
        m_sd = '0; m_fd = '0; m_sc = '0; m_fc = '0; m_blank = 1'b0;
        e = '{en: 8'hFF, dn: 8'hFF, fs: 1'b0};
      end else begin
        old_sd = m_sd;
        old_sc = m_sc;
        if (!started) begin
          started = 1'b1; t = 0;
        end else begin
          t = (t + 1) % FRAME;
        end
        if (t == 0) begin
          m_fd = old_sd;
          m_fc = old_sc[15:0];
        end
        m_blank = old_sc[16];
        if (we && addr == DADDR) m_sd = wdata;
        if (we && addr == CADDR) begin
`ifdef DIG_DP_EN
          m_sc = wdata[16:0];
`else
          m_sc = {wdata[16], 8'h00, wdata[7:0]};
`endif
        end
        slot = t / SLOT;
        pos  = t % SLOT;
        e = '{en: 8'hFF, dn: 8'hFF, fs: (t == 0)};
        if (pos >= GAPC) begin
`ifdef DIG_DP_EN
          dp = m_fc[8 + slot];
`else
          dp = 1'b0;
`endif
          e.dn = {~dp, ~seg7(m_fd[slot*4 +: 4])};
          if (m_fc[slot] && !m_blank) e.en = ~(8'h01 << slot);
        end
      end
      q.push_back(e);
    end
  end

  // Monitor: compares every presented output cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (dig_en !== e.en || dig_dn !== e.dn || fs !== e.fs) begin
          failures++;
          $display("FAIL cycle_out t=%0d: got en=%h dn=%h fs=%b, want en=%h dn=%h fs=%b",
                   t, dig_en, dig_dn, fs, e.en, e.dn, e.fs);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = '0;
  endtask

  task automatic wait_pos(input int slot, input int pos);
    int n;
    n = 0;
    while (!(started && (t / SLOT) == slot && (t % SLOT) == pos) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) begin
      checks++;
      failures++;
      $display("FAIL wait_pos timeout slot=%0d pos=%0d: got t=%0d, want reached", slot, pos, t);
    end
  endtask

  initial begin
    logic [31:0] d;
    idle(3);
    rst = 1'b0;
    idle(2 * FRAME + 5);

    wr(DADDR, 32'h7654_3210);
    wr(CADDR, 32'h0000_00FF);
    idle(FRAME + 20);

    wr(CADDR, 32'h0000_0005);
    idle(FRAME + 10);

    wait_pos(3, 4);
    wr(DADDR, 32'hFFFF_FFFF);
    idle(FRAME + 20);

    wr(CADDR, 32'h0000_00FF);
    wait_pos(2, 5);
    wr(CADDR, 32'h0001_00FF);
    idle(25);
    wr(CADDR, 32'h0000_00FF);
    idle(FRAME);

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        0: wr(DADDR, d);
        1: wr(CADDR, ($urandom_range(0, 3) == 0) ? d : (d & 32'hFFFE_FFFF));
        2: wr($urandom, d);
        default: wr(CADDR + 32'd8, d);
      endcase
      idle($urandom_range(0, 25));
    end

    wr(DADDR, 32'h7654_3210);
    wr(CADDR, 32'h0000_01FF);
    idle(FRAME + 5);

    wait_pos(0, 5);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dig_en !== 8'hFF || dig_dn !== 8'hFF || fs !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got en=%h dn=%h fs=%b, want en=ff dn=ff fs=0", dig_en, dig_dn, fs);
    end
    idle(3);
    rst = 1'b0;
    idle(FRAME + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
